// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier.
// Each clock performs one add/subtract-and-shift step, so a product takes
// WORD_LENGTH clocks after the start edge. A done pulse flags a fresh product,
// which is then held until the next result replaces it.
module booth_seq_multiplier #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(WORD_LENGTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  // A carries one guard bit so that A-M cannot overflow when M is the most
  // negative operand.
  logic [WORD_LENGTH:0]        a_q, a_d;
  logic [WORD_LENGTH:0]        m_q, m_d;
  logic [WORD_LENGTH-1:0]      q_q, q_d;
  logic                        q1_q, q1_d;
  logic [CW-1:0]               count_q, count_d;
  logic [2*WORD_LENGTH-1:0]    product_q, product_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [WORD_LENGTH:0]        booth_sum_s;
  logic [WORD_LENGTH:0]        a_shift_s;
  logic [WORD_LENGTH-1:0]      q_shift_s;
  logic                        q1_shift_s;

  // One Booth step: select add/subtract/hold from {Q[0],Q_1}, then shift right arithmetically.
  always_comb begin
    booth_sum_s = a_q;
    case ({q_q[0], q1_q})
      2'b01:   booth_sum_s = a_q + m_q;
      2'b10:   booth_sum_s = a_q - m_q;
      default: booth_sum_s = a_q;
    endcase
    a_shift_s  = {booth_sum_s[WORD_LENGTH], booth_sum_s[WORD_LENGTH:1]};
    q_shift_s  = {booth_sum_s[0], q_q[WORD_LENGTH-1:1]};
    q1_shift_s = q_q[0];
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = {(WORD_LENGTH+1){1'b0}};
          m_d     = {multiplicand[WORD_LENGTH-1], multiplicand};
          q_d     = multiplier;
          q1_d    = 1'b0;
          count_d = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_shift_s;
        q_d     = q_shift_s;
        q1_d    = q1_shift_s;
        count_d = count_q + CW'(1);
        if (count_q == LAST_ITER) begin
          product_d = {a_shift_s[WORD_LENGTH-1:0], q_shift_s};
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Start is deliberately ignored here; it must be seen again in IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      a_q       <= {(WORD_LENGTH+1){1'b0}};
      m_q       <= {(WORD_LENGTH+1){1'b0}};
      q_q       <= {WORD_LENGTH{1'b0}};
      q1_q      <= 1'b0;
      count_q   <= {CW{1'b0}};
      product_q <= {(2*WORD_LENGTH){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
